if_fetch: RTL and testbench

Instruction fetch stage directly downstream of the PC generator. It issues instruction-memory reads at the current PC and tracks in-flight requests. Returned instructions are buffered, with their PCs, toward decode through a valid/ready handshake. It produces the PC generator's `hold` and discards wrong-path fetches when a branch flush is signalled.

---
 rtl/if_fetch.sv | 131 +++++++++++++
 tb/tb_if_fetch.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch
// Description : Instruction fetch stage. Issues imem reads at the PC, tracks
//               in-flight requests, buffers {pc, inst} toward decode and
//               discards wrong-path responses after a branch flush.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic                  flush,
    output logic                  hold_o,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [INST_WIDTH-1:0] imem_resp_data,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [INST_WIDTH-1:0] id_inst,
    output logic [ADDR_WIDTH-1:0] id_pc
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_SUM_W = c_CNT_W + 2;
    localparam logic [c_SUM_W-1:0] c_DEPTH = c_SUM_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_pcq_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_pcq_wr;
    logic [c_PTR_W-1:0]    r_pcq_rd;

    logic [ADDR_WIDTH-1:0] r_ob_pc   [DEPTH];
    logic [INST_WIDTH-1:0] r_ob_inst [DEPTH];
    logic [c_PTR_W-1:0]    r_ob_wr;
    logic [c_PTR_W-1:0]    r_ob_rd;

    logic [c_CNT_W-1:0]    r_out_cnt;
    logic [c_CNT_W-1:0]    r_drop_cnt;
    logic [c_CNT_W-1:0]    r_ob_cnt;

    logic                  w_id_fire;
    logic                  w_req_fire;
    logic                  w_resp_keep;
    logic                  w_resp_drop;
    logic [c_SUM_W-1:0]    w_used;
    logic [c_SUM_W-1:0]    w_owed;
    logic [c_SUM_W-1:0]    w_flush_drop;

    assign id_valid      = (r_ob_cnt != '0);
    assign id_pc         = r_ob_pc[r_ob_rd];
    assign id_inst       = r_ob_inst[r_ob_rd];
    assign imem_req_addr = pc_in;

    assign w_id_fire = id_valid & id_ready;

    // A slot released by decode this cycle can be reissued in the same cycle.
    assign w_used = c_SUM_W'(r_out_cnt) + c_SUM_W'(r_drop_cnt)
                  + c_SUM_W'(r_ob_cnt) - c_SUM_W'(w_id_fire);

    assign imem_req_valid = !rst & !flush & (w_used < c_DEPTH);
    assign w_req_fire     = imem_req_valid & imem_req_ready;
    assign hold_o         = rst | !(w_req_fire | flush);

    // Responses with nothing owed (e.g. right after reset) are ignored.
    assign w_resp_drop = imem_resp_valid & (r_drop_cnt != '0);
    assign w_resp_keep = imem_resp_valid & (r_drop_cnt == '0) & (r_out_cnt != '0);

    assign w_owed       = c_SUM_W'(r_drop_cnt) + c_SUM_W'(r_out_cnt);
    assign w_flush_drop = w_owed - c_SUM_W'(imem_resp_valid & (w_owed != '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcq_wr   <= '0;
            r_pcq_rd   <= '0;
            r_ob_wr    <= '0;
            r_ob_rd    <= '0;
            r_out_cnt  <= '0;
            r_drop_cnt <= '0;
            r_ob_cnt   <= '0;
        end else if (flush) begin
            r_pcq_wr   <= '0;
            r_pcq_rd   <= '0;
            r_ob_wr    <= '0;
            r_ob_rd    <= '0;
            r_out_cnt  <= '0;
            r_ob_cnt   <= '0;
            r_drop_cnt <= c_CNT_W'(w_flush_drop);
        end else begin
            if (w_req_fire) begin
                r_pcq_wr <= r_pcq_wr + c_PTR_W'(1);
            end
            if (w_resp_keep) begin
                r_pcq_rd <= r_pcq_rd + c_PTR_W'(1);
                r_ob_wr  <= r_ob_wr + c_PTR_W'(1);
            end
            if (w_id_fire) begin
                r_ob_rd <= r_ob_rd + c_PTR_W'(1);
            end
            r_out_cnt  <= r_out_cnt + c_CNT_W'(w_req_fire) - c_CNT_W'(w_resp_keep);
            r_drop_cnt <= r_drop_cnt - c_CNT_W'(w_resp_drop);
            r_ob_cnt   <= r_ob_cnt + c_CNT_W'(w_resp_keep) - c_CNT_W'(w_id_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pcq_mem[i] <= '0;
                r_ob_pc[i]   <= '0;
                r_ob_inst[i] <= '0;
            end
        end else if (!flush) begin
            if (w_req_fire) begin
                r_pcq_mem[r_pcq_wr] <= pc_in;
            end
            if (w_resp_keep) begin
                r_ob_pc[r_ob_wr]   <= r_pcq_mem[r_pcq_rd];
                r_ob_inst[r_ob_wr] <= imem_resp_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch
// Description : Directed self-checking bench for if_fetch with a PC generator
//               and an in-order, fixed-latency instruction memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in = '0;
    logic        flush = 1'b0;
    logic        hold_o;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    if_fetch #(.ADDR_WIDTH(32), .INST_WIDTH(32), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .flush          (flush),
        .hold_o         (hold_o),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        mq[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_inst[$];
    logic [31:0] pc = '0;
    logic [31:0] tgt = '0;
    int          lat = 1;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          found;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'd3) ^ 32'h1357_9BDF;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: sample fires, advance the PC/memory models, redrive inputs.
    task automatic tick();
        logic        rf, idf, hs, fl, rs, rv;
        logic [31:0] ra, ip, ii;
        #1;
        rf = imem_req_valid & imem_req_ready;
        ra = imem_req_addr;
        idf = id_valid & id_ready;
        ip = id_pc;
        ii = id_inst;
        hs = hold_o;
        fl = flush;
        rs = rst;
        rv = imem_resp_valid;
        @(posedge clk);
        #1;
        if (rs) begin
            mq.delete();
            pc = '0;
        end else begin
            if (rv && mq.size() > 0) void'(mq.pop_front());
            if (rf) mq.push_back('{addr: ra, due: cyc + lat});
            if (idf) begin
                got_pc.push_back(ip);
                got_inst.push_back(ii);
            end
            if (fl) pc = tgt;
            else if (!hs) pc = pc + 32'd4;
        end
        cyc++;
        pc_in = pc;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = inst_of(mq[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        got_pc.delete();
        got_inst.delete();
        #1;
    endtask

    function automatic logic [31:0] got_at(input int i);
        return (i < got_pc.size()) ? got_pc[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] inst_at(input int i);
        return (i < got_inst.size()) ? got_inst[i] : 32'hDEAD_DEAD;
    endfunction

    initial begin
        // Reset values
        rst = 1'b1;
        tick();
        tick();
        check_val("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_val("rst_hold", 32'(hold_o), 32'd1);
        check_val("rst_id_valid", 32'(id_valid), 32'd0);
        check_val("rst_id_inst", id_inst, 32'd0);
        check_val("rst_id_pc", id_pc, 32'd0);

        // Streaming, latency 1
        lat = 1; id_ready = 1'b1; imem_req_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            check_val("stream_hold", 32'(hold_o), 32'd0);
            if (k >= 2) begin
                check_val("stream_valid", 32'(id_valid), 32'd1);
                check_val("stream_pc", id_pc, 32'(4 * (k - 2)));
                check_val("stream_inst", id_inst, inst_of(32'(4 * (k - 2))));
            end
            tick();
        end

        // Backpressure: decode stalled for 5 cycles
        id_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            if (k >= 2) begin
                check_val("bp_req_valid", 32'(imem_req_valid), 32'd0);
                check_val("bp_hold", 32'(hold_o), 32'd1);
                check_val("bp_id_pc", id_pc, 32'd0);
                check_val("bp_id_inst", id_inst, inst_of(32'd0));
            end
            tick();
        end
        id_ready = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        for (int i = 0; i < 5; i++) begin
            check_val("bp_order_pc", got_at(i), 32'(4 * i));
            check_val("bp_order_inst", inst_at(i), inst_of(32'(4 * i)));
        end

        // Flush with PC 8 and 12 in flight, latency 3
        lat = 3; id_ready = 1'b1;
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (mq.size() == 2 && mq[0].addr == 32'd8) found = 1'b1;
            else tick();
        end
        check_val("fl_setup", 32'(found), 32'd1);
        tgt = 32'h100;
        flush = 1'b1;
        #1;
        check_val("fl_no_req", 32'(imem_req_valid), 32'd0);
        got_pc.delete();
        got_inst.delete();
        tick();
        flush = 1'b0;
        for (int k = 0; k < 16; k++) tick();
        check_val("fl_first_pc", got_at(0), 32'h100);
        check_val("fl_first_inst", inst_at(0), inst_of(32'h100));
        check_val("fl_second_pc", got_at(1), 32'h104);

        // Flush in the same cycle as a response, latency 2
        lat = 2;
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (imem_resp_valid && mq.size() == 2) found = 1'b1;
            else tick();
        end
        check_val("flr_setup", 32'(found), 32'd1);
        tgt = 32'h200;
        flush = 1'b1;
        got_pc.delete();
        got_inst.delete();
        tick();
        flush = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        check_val("flr_first_pc", got_at(0), 32'h200);
        check_val("flr_first_inst", inst_at(0), inst_of(32'h200));
        check_val("flr_second_pc", got_at(1), 32'h204);

        // Request stall for 4 cycles
        lat = 1; imem_req_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            check_val("stall_hold", 32'(hold_o), 32'd1);
            check_val("stall_addr", imem_req_addr, 32'd0);
            tick();
        end
        imem_req_ready = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        for (int i = 0; i < 4; i++) check_val("stall_order", got_at(i), 32'(4 * i));

        // Reset with two instructions buffered
        id_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 4; k++) tick();
        check_val("mr_pre_valid", 32'(id_valid), 32'd1);
        rst = 1'b1;
        tick();
        check_val("mr_id_valid", 32'(id_valid), 32'd0);
        check_val("mr_req_valid", 32'(imem_req_valid), 32'd0);
        check_val("mr_hold", 32'(hold_o), 32'd1);
        rst = 1'b0;
        id_ready = 1'b1;
        got_pc.delete();
        got_inst.delete();
        #1;
        for (int k = 0; k < 6; k++) tick();
        for (int i = 0; i < 3; i++) check_val("mr_restart", got_at(i), 32'(4 * i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
